// File: rtl/tri_bus_owner_arbiter.sv
// Round-robin owner arbiter feeding the tri-state enables of a shared wired bus.
// Define TRI_BUS_TURNAROUND_EN to insert one all-zero TURN cycle between owners.
module tri_bus_owner_arbiter #(
    parameter int NREQ    = 4,
    parameter int MAXHOLD = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ-1:0]              done,
    output logic [NREQ-1:0]              grant,
    output logic [NREQ-1:0]              drive_en,
    output logic [$clog2(NREQ)-1:0]      owner_id,
    output logic                         busy,
    output logic [$clog2(MAXHOLD+1)-1:0] hold_cnt,
    output logic                         timeout
);
    localparam int IW = $clog2(NREQ);
    localparam int HW = $clog2(MAXHOLD+1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAXHOLD);
    localparam logic [IW-1:0] LAST_ID  = IW'(NREQ - 1);

`ifdef TRI_BUS_TURNAROUND_EN
    typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_OWN} state_t;
`endif

    state_t          state, state_n;
    logic [NREQ-1:0] grant_n;
    logic [IW-1:0]   owner_n, ptr, ptr_n, owner_next, arb_base, arb_win;
    logic [HW-1:0]   hold_n;
    logic            timeout_n, arb_found, release_now, at_limit;
    int              idx;

    assign owner_next  = (owner_id == LAST_ID) ? '0 : owner_id + 1'b1;
    assign at_limit    = (hold_cnt == HOLD_MAX);
    assign release_now = done[owner_id] | ~req[owner_id] | at_limit;

    // A release arbitrates with the pointer already moved past the leaving owner.
    assign arb_base = (state == S_OWN) ? owner_next : ptr;

    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(arb_base) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!arb_found && req[idx]) begin
                arb_found = 1'b1;
                arb_win   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        owner_n   = owner_id;
        hold_n    = hold_cnt;
        timeout_n = 1'b0;
        ptr_n     = ptr;
        case (state)
            S_IDLE: begin
                if (arb_found) begin
                    grant_n          = '0;
                    grant_n[arb_win] = 1'b1;
                    owner_n          = arb_win;
                    hold_n           = HW'(1);
                    state_n          = S_OWN;
                end
            end
            S_OWN: begin
                if (!release_now) begin
                    hold_n = hold_cnt + 1'b1;
                end else begin
                    ptr_n     = owner_next;
                    timeout_n = at_limit & ~done[owner_id] & req[owner_id];
                    grant_n   = '0;
                    hold_n    = '0;
`ifdef TRI_BUS_TURNAROUND_EN
                    state_n   = S_TURN;
`else
                    if (arb_found) begin
                        grant_n[arb_win] = 1'b1;
                        owner_n          = arb_win;
                        hold_n           = HW'(1);
                        state_n          = S_OWN;
                    end else begin
                        state_n = S_IDLE;
                    end
`endif
                end
            end
`ifdef TRI_BUS_TURNAROUND_EN
            S_TURN: begin
                if (arb_found) begin
                    grant_n          = '0;
                    grant_n[arb_win] = 1'b1;
                    owner_n          = arb_win;
                    hold_n           = HW'(1);
                    state_n          = S_OWN;
                end else begin
                    state_n = S_IDLE;
                end
            end
`endif
            default: begin
                state_n = S_IDLE;
                grant_n = '0;
                hold_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            grant    <= '0;
            owner_id <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
            ptr      <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            owner_id <= owner_n;
            hold_cnt <= hold_n;
            timeout  <= timeout_n;
            ptr      <= ptr_n;
        end
    end

    assign drive_en = grant;
    assign busy     = |grant;
endmodule

// File: tb/tb_tri_bus_owner_arbiter.sv
// Vector bench for tri_bus_owner_arbiter (NREQ=4, MAXHOLD=8): hand-derived
// expected outputs are queued per driven cycle and checked after the edge.
module tb_tri_bus_owner_arbiter;
    localparam int NREQ    = 4;
    localparam int MAXHOLD = 8;
    localparam int W       = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, done;
    logic [3:0] grant, drive_en;
    logic [1:0] owner_id;
    logic       busy, timeout;
    logic [3:0] hold_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] grant;
        logic [1:0] owner;
        logic [3:0] hold;
        logic       tmo;
    } vec_t;

    vec_t tbl[$];

    tri_bus_owner_arbiter #(.NREQ(NREQ), .MAXHOLD(MAXHOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(grant), .drive_en(drive_en), .owner_id(owner_id),
        .busy(busy), .hold_cnt(hold_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] d,
                                input logic [3:0] g, input logic [1:0] o,
                                input logic [3:0] h, input logic t);
        vec_t v;
        v.rst = r; v.req = rq; v.done = d; v.grant = g; v.owner = o; v.hold = h; v.tmo = t;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic [W-1:0] got, want;
        rst  = v.rst;
        req  = v.req;
        done = v.done;
        exp_q.push_back({v.grant, v.grant, v.owner, |v.grant, v.hold, v.tmo});
        @(posedge clk);
        #1;
        got  = {grant, drive_en, owner_id, busy, hold_cnt, timeout};
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got g=%b en=%b id=%0d busy=%b hold=%0d tmo=%b want g=%b en=%b id=%0d busy=%b hold=%0d tmo=%b",
                     name, got[15:12], got[11:8], got[7:6], got[5], got[4:1], got[0],
                     want[15:12], want[11:8], want[7:6], want[5], want[4:1], want[0]);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; done = '0;

`ifndef TRI_BUS_TURNAROUND_EN
        // reset, single request, drop of req
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 2, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 2, 0, 0));
        // owner 3 drops req without done: pointer wraps to 0
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 4'b1000, 3, 1, 0));
        tbl.push_back(mk(0, 4'b1001, 4'b0000, 4'b1000, 3, 2, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0000, 4'b0001, 0, 1, 0));
        // round robin, done on 2nd grant cycle, zero-gap handoff
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 0, 2, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0010, 1, 2, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0010, 4'b0100, 2, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1011, 4'b0100, 2, 2, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0100, 4'b1000, 3, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b1000, 3, 2, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1000, 4'b0001, 0, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
        // sole requester runs into the hold limit
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0));
        for (int h = 2; h <= MAXHOLD; h++)
            tbl.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 1, 4'(h), 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 1, 1, 1));
        for (int h = 2; h <= MAXHOLD; h++)
            tbl.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 1, 4'(h), 0));
        // done together with the limit is a normal release
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("table[%0d]", i));
`endif

        // handoff 0 -> 1 with done on 3rd grant cycle
        apply(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0), "turn_rst");
        apply(mk(0, 4'b0011, 4'b0000, 4'b0001, 0, 1, 0), "turn_g1");
        apply(mk(0, 4'b0011, 4'b0000, 4'b0001, 0, 2, 0), "turn_g2");
        apply(mk(0, 4'b0011, 4'b0000, 4'b0001, 0, 3, 0), "turn_g3");
`ifdef TRI_BUS_TURNAROUND_EN
        apply(mk(0, 4'b0011, 4'b0001, 4'b0000, 0, 0, 0), "turn_gap");
        apply(mk(0, 4'b0011, 4'b0000, 4'b0010, 1, 1, 0), "turn_next");
`else
        apply(mk(0, 4'b0011, 4'b0001, 4'b0010, 1, 1, 0), "turn_next");
`endif

        // reset in the middle of a tenure
        apply(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0), "mid_rst0");
        apply(mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0), "mid_g1");
        for (int h = 2; h <= 5; h++)
            apply(mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 4'(h), 0), $sformatf("mid_g%0d", h));
        apply(mk(1, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0), "mid_rst");
        apply(mk(0, 4'b1111, 4'b0000, 4'b0001, 0, 1, 0), "mid_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
